// File: rtl/jt900h_divx_if.sv
// Operand/result bundle between the execution unit and the divider.
interface jt900h_divx_if #(
  parameter int DW = 16
);
  logic [2*DW-1:0] op0;
  logic [DW-1:0]   op1;
  logic            len;
  logic            sgn;
  logic            start;
  logic [DW-1:0]   quot;
  logic [DW-1:0]   rem;
  logic            busy;
  logic            done;
  logic            v;
  logic            dbz;

  modport master (
    output op0, op1, len, sgn, start,
    input  quot, rem, busy, done, v, dbz
  );

  modport slave (
    input  op0, op1, len, sgn, start,
    output quot, rem, busy, done, v, dbz
  );
endinterface

// File: rtl/jt900h_divx.sv
// Restoring divider for the TLCS-900H ALU: 2N/N bits, signed or unsigned,
// long (N=DW) or short (N=DW/2) mode, one quotient bit per enabled clock.
module jt900h_divx #(
  parameter int DW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  jt900h_divx_if.slave   bus
);
  localparam int H  = DW / 2;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            long_q, long_d;
  logic            sgn_q, sgn_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            err_q, err_d;
  logic            dz_q, dz_d;
  logic [DW-1:0]   dvs_q, dvs_d;
  logic [DW:0]     prem_q, prem_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic [DW-1:0]   raw_q, raw_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [DW-1:0]   quot_q, quot_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            v_q, v_d;
  logic            dbz_q, dbz_d;

  // Operand preparation for an incoming start
  logic [2*DW-1:0] dvd_l;
  logic [DW-1:0]   op0_s, dvd_s;
  logic [H-1:0]    op1_s;
  logic [DW-1:0]   hi_m, lo_m, dvs_m, raw_m;
  logic            sa_m, sb_m;
  // Restoring step and result fix-up
  logic [DW:0]     trial, diff;
  logic            ge;
  logic [CW-1:0]   last_idx;
  logic [DW-1:0]   mask, half, qn, rn;
  logic            neg_q, ovf;

  // Magnitudes, signs and partial-remainder seed from the current operands
  always_comb begin
    op0_s = bus.op0[DW-1:0];
    op1_s = bus.op1[H-1:0];
    sa_m  = bus.sgn & (bus.len ? bus.op0[2*DW-1] : op0_s[DW-1]);
    sb_m  = bus.sgn & (bus.len ? bus.op1[DW-1]   : op1_s[H-1]);
    dvd_l = sa_m ? ('0 - bus.op0) : bus.op0;
    dvd_s = sa_m ? ('0 - op0_s)   : op0_s;
    if (bus.len) begin
      hi_m  = dvd_l[2*DW-1:DW];
      lo_m  = dvd_l[DW-1:0];
      dvs_m = sb_m ? ('0 - bus.op1) : bus.op1;
      raw_m = op0_s;
    end else begin
      // Short dividend bits are left-aligned so both modes shift from the top.
      hi_m  = {{H{1'b0}}, dvd_s[DW-1:H]};
      lo_m  = {dvd_s[H-1:0], {H{1'b0}}};
      dvs_m = {{H{1'b0}}, (sb_m ? ('0 - op1_s) : op1_s)};
      raw_m = {{H{1'b0}}, op0_s[H-1:0]};
    end
  end

  // One restoring step plus the sign/range fix-up of the final result
  always_comb begin
    trial    = {prem_q[DW-1:0], lo_q[DW-1]};
    diff     = trial - {1'b0, dvs_q};
    ge       = trial >= {1'b0, dvs_q};
    last_idx = long_q ? CW'(DW - 1) : CW'(H - 1);
    mask     = long_q ? {DW{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
    half     = '0;
    half[long_q ? DW - 1 : H - 1] = 1'b1;
    neg_q    = sa_q ^ sb_q;
    qn       = (neg_q ? ('0 - quo_q) : quo_q) & mask;
    rn       = (sa_q ? ('0 - prem_q[DW-1:0]) : prem_q[DW-1:0]) & mask;
    ovf      = sgn_q & (neg_q ? (quo_q > half) : (quo_q >= half));
  end

  // Next-state logic for the IDLE/RUN/FIX sequencer and all outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    long_d  = long_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    err_d   = err_q;
    dz_d    = dz_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    lo_d    = lo_q;
    raw_d   = raw_q;
    quo_d   = quo_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    v_d     = v_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          long_d = bus.len;
          sgn_d  = bus.sgn;
          sa_d   = sa_m;
          sb_d   = sb_m;
          dvs_d  = dvs_m;
          prem_d = {1'b0, hi_m};
          lo_d   = lo_m;
          raw_d  = raw_m;
          quo_d  = '0;
          cnt_d  = '0;
          v_d    = 1'b0;
          dbz_d  = 1'b0;
          busy_d = 1'b1;
          dz_d   = (dvs_m == '0);
          err_d  = (dvs_m == '0) || (hi_m >= dvs_m);
          state_d = ((dvs_m == '0) || (hi_m >= dvs_m)) ? FIX : RUN;
        end
      end
      RUN: begin
        prem_d = ge ? diff : trial;
        lo_d   = {lo_q[DW-2:0], 1'b0};
        quo_d  = {quo_q[DW-2:0], ge};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == last_idx) state_d = FIX;
      end
      FIX: begin
        if (err_q) begin
          quot_d = mask;
          rem_d  = raw_q;
          v_d    = 1'b1;
          dbz_d  = dz_q;
        end else begin
          quot_d = qn;
          rem_d  = rn;
          v_d    = ovf;
          dbz_d  = 1'b0;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, advancing only on enabled edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
      dvs_q   <= '0;
      prem_q  <= '0;
      lo_q    <= '0;
      raw_q   <= '0;
      quo_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v_q     <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (cen) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      long_q  <= long_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      lo_q    <= lo_d;
      raw_q   <= raw_d;
      quo_q   <= quo_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      v_q     <= v_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.v    = v_q;
  assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_jt900h_divx.sv
// Directed bench for jt900h_divx (DW=16).
module tb_jt900h_divx;
  logic clk;
  logic rst_n;
  logic cen;
  int   checks;
  int   errors;

  jt900h_divx_if #(.DW(16)) bus ();

  jt900h_divx #(.DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op0;
    logic [15:0] op1;
    logic        len;
    logic        sgn;
    logic [15:0] q;
    logic [15:0] r;
    logic        v;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int n;
    bit got;
    bus.op0   = t.op0;
    bus.op1   = t.op1;
    bus.len   = t.len;
    bus.sgn   = t.sgn;
    cen       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk($sformatf("busy_start[%0d]", idx), 32'(bus.busy), 32'd1);
    n = 0;
    got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) got = 1;
    end
    chk($sformatf("latency[%0d]", idx), 32'(n), 32'(t.lat));
    chk($sformatf("quot[%0d]", idx), 32'(bus.quot), 32'(t.q));
    chk($sformatf("rem[%0d]", idx), 32'(bus.rem), 32'(t.r));
    chk($sformatf("v[%0d]", idx), 32'(bus.v), 32'(t.v));
    chk($sformatf("dbz[%0d]", idx), 32'(bus.dbz), 32'(t.dbz));
    chk($sformatf("busy_end[%0d]", idx), 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk($sformatf("done_clr[%0d]", idx), 32'(bus.done), 32'd0);
    chk($sformatf("v_hold[%0d]", idx), 32'(bus.v), 32'(t.v));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_quot"}, 32'(bus.quot), 32'd0);
    chk({tag, "_rem"},  32'(bus.rem),  32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_v"},    32'(bus.v),    32'd0);
    chk({tag, "_dbz"},  32'(bus.dbz),  32'd0);
  endtask

  initial begin
    int  cnt, lat, dcount;
    bit  ce, prev_done;

    checks = 0;
    errors = 0;
    //          op0           op1      len   sgn   q         r         v     dbz   lat
    vt[0]  = '{32'h00012345, 16'h0010, 1'b1, 1'b0, 16'h1234, 16'h0005, 1'b0, 1'b0, 17};
    vt[1]  = '{32'h00000100, 16'h0003, 1'b0, 1'b0, 16'h0055, 16'h0001, 1'b0, 1'b0, 9};
    vt[2]  = '{32'hFFFFFF9C, 16'h0007, 1'b1, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17};
    vt[3]  = '{32'h00001234, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b1, 1};
    vt[4]  = '{32'h00010000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1};
    vt[5]  = '{32'h00008000, 16'h0001, 1'b1, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0, 17};
    vt[6]  = '{32'hABCDFF9C, 16'h5507, 1'b0, 1'b1, 16'h00F2, 16'h00FE, 1'b0, 1'b0, 9};
    vt[7]  = '{32'h0000FF00, 16'h0002, 1'b0, 1'b1, 16'h0080, 16'h0000, 1'b0, 1'b0, 9};
    vt[8]  = '{32'h00000100, 16'h0002, 1'b0, 1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0, 9};
    vt[9]  = '{32'hFFFE0001, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
    vt[10] = '{32'h00000064, 16'hFFF9, 1'b1, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17};
    vt[11] = '{32'h00001234, 16'hFF00, 1'b0, 1'b0, 16'h00FF, 16'h0034, 1'b1, 1'b1, 1};

    rst_n     = 1'b0;
    cen       = 1'b1;
    bus.op0   = '0;
    bus.op1   = '0;
    bus.len   = 1'b1;
    bus.sgn   = 1'b0;
    bus.start = 1'b0;
    #3;
    chk_zero("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // 50% clock enable with start held high while busy
    bus.op0   = 32'h00012345;
    bus.op1   = 16'h0010;
    bus.len   = 1'b1;
    bus.sgn   = 1'b0;
    cen       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
    cnt = 0;
    lat = 0;
    dcount = 0;
    prev_done = 0;
    for (int i = 0; i < 60; i++) begin
      ce = cen;
      @(posedge clk); #1;
      if (ce) cnt++;
      if (bus.done && !prev_done) begin
        dcount++;
        if (lat == 0) lat = cnt;
        bus.start = 1'b0;
      end
      prev_done = bus.done;
      cen = ~cen;
    end
    bus.start = 1'b0;
    chk("cen_latency", 32'(lat), 32'd17);
    chk("cen_done_count", 32'(dcount), 32'd1);
    chk("cen_quot", 32'(bus.quot), 32'h1234);
    chk("cen_rem", 32'(bus.rem), 32'h0005);
    chk("cen_busy", 32'(bus.busy), 32'd0);
    chk("cen_done_clr", 32'(bus.done), 32'd0);

    // Asynchronous reset in the middle of RUN
    cen       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    chk("midrun_busy", 32'(bus.busy), 32'd1);
    chk("midrun_quot_held", 32'(bus.quot), 32'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrun_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) dcount++;
    end
    chk("post_rst_idle", 32'(dcount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt900h_divx.md
# jt900h_divx

Parametrised restoring divider for the TLCS-900H ALU: 2N/N-bit dividend/divisor, unsigned (DIV) or signed (DIVS), in long (N=DW) or short (N=DW/2) mode. One quotient bit per clock-enable cycle. Also flags divide-by-zero and quotient overflow. Sits beside the ALU and is started by the execution unit, which stalls on `busy` and samples results on `done`.

## Interface
- DW, 16, long-mode divisor/quotient/remainder width; even, ≥4; short mode uses DW/2

- clk     in   1      system clock
- rst_n   in   1      reset, asynchronous, active-low
- cen     in   1      clock enable; all state changes only on edges with cen=1
- op0     in   2*DW   dividend; short mode uses op0[DW-1:0]
- op1     in   DW     divisor; short mode uses op1[DW/2-1:0]
- len     in   1      1 = long (N=DW), 0 = short (N=DW/2)
- sgn     in   1      1 = signed two's-complement, 0 = unsigned
- start   in   1      request; accepted on a cen edge only when busy=0
- quot    out  DW     quotient; short mode: bits above N-1 are 0
- rem     out  DW     remainder; short mode: bits above N-1 are 0
- busy    out  1      operation in progress
- done    out  1      results valid; high for exactly one cen-qualified period
- v       out  1      overflow, set together with done
- dbz     out  1      divide by zero, set together with done

## Operation
- Reset (rst_n=0, immediate): quot=0, rem=0, busy=0, done=0, v=0, dbz=0, FSM=IDLE, counter=0.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch mode, N, |dividend| (2N bits), |divisor| (N bits), dividend sign sa and divisor sign sb. Magnitudes are taken only when sgn=1.
  - Clear v, dbz and done.
  - Set busy=1.
  - If divisor=0: dbz=1, v=1, go to FIX with the error flag.
  - Else if |dividend|[2N-1:N] ≥ |divisor|: v=1, go to FIX with the error flag.
  - Else go to RUN with counter=0.
- RUN: each cen edge does one restoring step on the partial remainder (N+1 bits): shift in the next dividend bit, compare with divisor, subtract when ≥, shift the compare bit into the quotient. After N steps, go to FIX.
- FIX, one cen edge:
  - Error flag set: quot = all ones in bits [N-1:0]; rem = op0 low N bits as latched.
  - Otherwise: quotient negated if sa^sb; remainder negated if sa (remainder takes the dividend's sign).
  - Signed range check: v=1 if the quotient magnitude exceeds 2^(N-1)-1 (positive result) or 2^(N-1) (negative result). When this check sets v, quot and rem still carry the computed two's-complement values.
  - Then busy=0, done=1, FSM=IDLE.
- done, v and dbz hold until the next accepted start or reset. done alone clears on the next cen edge after being set.
- start while busy=1 is ignored; there is no abort.
- With cen=0: no state, counter or output changes. start is not sampled.
- Unsigned operation never sets v in FIX. Overflow there is fully determined by the precheck.

## Timing
- Edge E0: start accepted (cen=1, busy=0). busy=1 is visible after E0.
- Normal operation: RUN covers cen edges E1…EN. FIX is edge EN+1; after it busy=0 and done=1.
  - Latency is N+1 cen edges after E0: long DW=16 → 17, short → 9.
- Error path (dbz or precheck overflow): FIX at E1, so done follows after 1 cen edge.
- A new start may be accepted on the same edge on which done is set? No: busy is 1 during FIX. The earliest new start is the edge after FIX. That edge also clears done.
- Cycle counts are in cen-qualified edges. Wall-clock latency scales with the cen duty.
- Reset asserted mid-operation aborts immediately to the reset values; no done is produced.

## Test plan
- Unsigned long, DW=16: op0=0x00012345, op1=0x0010 → quot=0x1234, rem=0x0005, v=0, dbz=0; done after 17 cen edges.
- Unsigned short: op0=0x0100, op1=0x03, len=0 → quot=0x0055, rem=0x0001; done after 9 cen edges.
- Signed long: op0=0xFFFFFF9C (-100), op1=0x0007 → quot=0xFFF2 (-14), rem=0xFFFE (-2), v=0.
- Errors:
  - op1=0 → dbz=1, v=1, quot=0xFFFF, done 1 edge after start.
  - Unsigned 0x00010000/0x0001 → v=1, dbz=0.
  - Signed 0x00008000/0x0001 → v=1, quot=0x8000.
- cen toggling at 50% with a start pulse held while busy: result identical to the first case and a single done. Then deassert rst_n mid-RUN → all outputs return to 0 at once.
